// File: rtl/tc_cam_pkg.sv
// Shared definitions for the CAM result path: opcodes and beat field positions.
package tc_cam_pkg;

   typedef logic [3:0] op_t;

   localparam op_t IDLE              = 4'h0;
   localparam op_t UPDATE_ALL        = 4'h1;
   localparam op_t UPDATE_GROUP      = 4'h2;
   localparam op_t UPDATE_ONE        = 4'h3;
   localparam op_t SEARCH_ONE        = 4'h4;
   localparam op_t SEARCH_MQ         = 4'h5;
   localparam op_t SET_ROUTING_TABLE = 4'h6;
   localparam op_t RESET_ALL         = 4'h7;
   localparam op_t UPDATE_DUPLICATE  = 4'h8;
   localparam op_t END_OF_STREAM     = 4'hF;

   localparam int unsigned OP_MSB  = 518;
   localparam int unsigned OP_LSB  = 515;
   localparam int unsigned HIT_BIT = 0;

endpackage

// File: rtl/tc_result_fifo.sv
// Small synchronous FIFO for completed segment counts.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module tc_result_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic             aclk,
   input  logic             areset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             pop_en;
   logic             push_en;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer update and storage write; storage is cleared so the head reads zero after reset.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         mem    <= '{default: '0};
      end else begin
         if (push_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tc_cam_result_accum.sv
// Per-segment CAM hit counter feeding an AXI4-Stream count output.
// Optional macro TC_SEARCH_CNT_EN adds a search-beat counter packed above the hit count.
module tc_cam_result_accum
   import tc_cam_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH  = 520,
   parameter int unsigned C_COUNT_WIDTH = 64,
   parameter int unsigned FIFO_DEPTH    = 2
) (
   input  logic                       aclk,
   input  logic                       areset_n,
   input  logic                       s_tvalid,
   input  logic [C_DATA_WIDTH-1:0]    s_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
`ifdef TC_SEARCH_CNT_EN
   output logic [2*C_COUNT_WIDTH-1:0] m_tdata,
`else
   output logic [C_COUNT_WIDTH-1:0]   m_tdata,
`endif
   output logic                       ovf_err,
   output logic                       sat_err
);

`ifdef TC_SEARCH_CNT_EN
   localparam int unsigned ENTRY_W = 2 * C_COUNT_WIDTH;
`else
   localparam int unsigned ENTRY_W = C_COUNT_WIDTH;
`endif

   localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE = 1;

   op_t                op;
   logic               hit;
   logic               is_search;
   logic               is_eos;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] push_data;
   logic [ENTRY_W-1:0] fifo_head;
   logic [C_COUNT_WIDTH-1:0] acc;

   assign op        = s_tdata[OP_MSB:OP_LSB];
   assign hit       = s_tdata[HIT_BIT];
   assign is_search = s_tvalid && (op == SEARCH_MQ);
   assign is_eos    = s_tvalid && (op == END_OF_STREAM);
   assign pop       = m_tvalid && m_tready;

   // Hit accumulator: saturating increment on search hits, cleared on end of segment.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         acc <= '0;
      end else if (is_eos) begin
         acc <= '0;
      end else if (is_search && hit && !(&acc)) begin
         acc <= acc + CNT_ONE;
      end
   end

   // Sticky error flags: saturation on a hit at all-ones, dropped count on a full FIFO.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         sat_err <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         if (is_search && hit && (&acc)) begin
            sat_err <= 1'b1;
         end
         if (is_eos && fifo_full && !pop) begin
            ovf_err <= 1'b1;
         end
      end
   end

`ifdef TC_SEARCH_CNT_EN
   logic [C_COUNT_WIDTH-1:0] search_cnt;

   // Search-beat counter: every SEARCH_MQ beat counts, saturating, cleared on end of segment.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         search_cnt <= '0;
      end else if (is_eos) begin
         search_cnt <= '0;
      end else if (is_search && !(&search_cnt)) begin
         search_cnt <= search_cnt + CNT_ONE;
      end
   end

   assign push_data = {search_cnt, acc};
`else
   assign push_data = acc;
`endif

   tc_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk      (aclk),
      .areset_n  (areset_n),
      .push      (is_eos),
      .push_data (push_data),
      .full      (fifo_full),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty)
   );

   assign m_tvalid = !fifo_empty;
   assign m_tdata  = fifo_head;

endmodule
